// File: rtl/tanh_pkg.sv
// Shared Q1.15 constants, sample width and an index-width helper for the tanh scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tanh_pkg;

    // Sample width. The datapath is fixed Q1.15.
    localparam int DW = 16;

    localparam logic signed [15:0] Q15_ONE     = 16'sh7FFF;
    localparam logic signed [15:0] Q15_NEG_ONE = 16'sh8001;
    localparam logic signed [15:0] SAT_THRESH  = 16'sh7000;

    // Ceiling log2 with a floor of 1, so a 1- or 2-entry set still gets a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after ptr, searching cyclically.
// Latency: 0 cycles (purely combinational).
// Backpressure: en=0 forces an all-zero grant.
module rr_arbiter
    import tanh_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk ptr+1 .. ptr+N (mod N) and grant the first active request found.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tanh_approx_q15.sv
// Combinational Q1.15 tanh: 4-segment piecewise-linear chords through tanh(k/4), odd-symmetric.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the output follows the input.
module tanh_approx_q15
    import tanh_pkg::*;
(
    input  logic [DW-1:0] x,
    output logic [DW-1:0] y
);

    logic [15:0] neg_x;
    logic [14:0] mag;
    logic [12:0] off;
    logic [14:0] base;
    logic [12:0] slope;
    logic [25:0] prod;
    logic [14:0] ymag;

    assign neg_x = ~x + 16'd1;

    // Magnitude; -1.0 (0x8000) has no positive twin, so it is clamped to the largest positive code.
    always_comb begin
        mag = x[14:0];
        if (x[15]) begin
            mag = neg_x[15] ? 15'h7FFF : neg_x[14:0];
        end
    end

    assign off = mag[12:0];

    // Segment table: base = tanh(seg/4) in Q15, slope = rise over one quarter-unit segment.
    always_comb begin
        base  = 15'd0;
        slope = 13'd8026;
        case (mag[14:13])
            2'd0: begin base = 15'd0;     slope = 13'd8026; end
            2'd1: begin base = 15'd8026;  slope = 13'd7117; end
            2'd2: begin base = 15'd15143; slope = 13'd5670; end
            default: begin base = 15'd20813; slope = 13'd4143; end
        endcase
    end

    // Interpolate within the segment; the 2^13 divide truncates toward zero.
    assign prod = 26'(off) * 26'(slope);
    assign ymag = base + {2'b00, prod[25:13]};

    // Re-apply the sign so tanh(-x) = -tanh(x) exactly.
    assign y = x[15] ? (~{1'b0, ymag} + 16'd1) : {1'b0, ymag};

endmodule

// File: rtl/tanh_rr_scheduler.sv
// Shares one tanh_approx_q15 between NREQ valid/ready requesters, round-robin, results tagged by index.
// Latency: 1 cycle accept-to-out_valid; 1 sample/cycle sustained while out_ready=1.
// Backpressure: single output entry; out_valid & !out_ready holds it and blocks all grants. Option: TANH_SAT_COUNT_EN.
module tanh_rr_scheduler
    import tanh_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2      // must equal clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [IDW-1:0]      out_id,
    input  logic                out_ready,
    output logic [15:0]         sat_count
);

    logic [IDW-1:0]  rr_ptr;
    logic            can_issue;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [DW-1:0]   tanh_x;
    logic [DW-1:0]   tanh_y;
    logic            xfer;

    // A grant is only offered when the output slot is free or draining this cycle,
    // and never while reset is held.
    assign can_issue = !out_valid || out_ready;
    assign arb_en    = can_issue && rst_n;

    rr_arbiter #(
        .N  (NREQ),
        .PW (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |(req_valid & gnt);

    // Encode the one-hot grant and steer the granted sample into the shared tanh.
    always_comb begin
        gnt_idx = '0;
        tanh_x  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDW'(i);
                tanh_x  = req_data[i*DW +: DW];
            end
        end
    end

    tanh_approx_q15 u_tanh (
        .x (tanh_x),
        .y (tanh_y)
    );

    // Output entry and round-robin pointer; pointer moves only on a real transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= tanh_y;
            out_id    <= gnt_idx;
            rr_ptr    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TANH_SAT_COUNT_EN
    logic [15:0] sat_q;
    logic        sat_hit;

    assign sat_hit = ($signed(tanh_y) >= SAT_THRESH) || ($signed(tanh_y) <= -SAT_THRESH);

    // Count transfers whose result lands near +/-1; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 16'd0;
        end else if (xfer && sat_hit && (sat_q != 16'hFFFF)) begin
            sat_q <= sat_q + 16'd1;
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_tanh_rr_scheduler.sv
// Directed bench for tanh_rr_scheduler: table of single-requester vectors plus round-robin,
// backpressure, drop-out, async-reset and saturation-counter sequences.
// Expected tanh codes are hand-computed from the chord table (0, 8026, 15143, 20813, 24956 at k/4).
module tb_tanh_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 16;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [IDW-1:0]      out_id;
    logic                out_ready;
    logic [15:0]         sat_count;

    int errors = 0;
    int checks = 0;

    tanh_rr_scheduler #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[11];

    // Hand-computed tanh codes for the fairness pattern on requesters 0..3.
    logic [15:0] rr_exp[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [15:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        int diff;
        int exp_sat;
        logic [15:0] y_full;

        vecs[0]  = '{0, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 16'h2000, 16'h1F5A};
        vecs[2]  = '{2, 16'h4000, 16'h3B27};
        vecs[3]  = '{3, 16'h7FFF, 16'h617B};
        vecs[4]  = '{0, 16'h1000, 16'h0FAD};
        vecs[5]  = '{1, 16'h3000, 16'h2D40};
        vecs[6]  = '{2, 16'h6000, 16'h514D};
        vecs[7]  = '{3, 16'hC000, 16'hC4D9};
        vecs[8]  = '{0, 16'h8000, 16'h9E85};
        vecs[9]  = '{1, 16'hE000, 16'hE0A6};
        vecs[10] = '{2, 16'hFFFF, 16'h0000};

        rr_exp[0] = 16'h0000;
        rr_exp[1] = 16'h1F5A;
        rr_exp[2] = 16'h3B27;
        rr_exp[3] = 16'h617B;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset state, with requests present to show req_ready is gated.
        #2;
        req_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data",  32'(out_data),  32'h0);
        chk("reset_out_id",    32'(out_id),    32'h0);
        chk("reset_sat_count", 32'(sat_count), 32'h0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Fairness: all four valid, grant order 0,1,2,3,0,... one result per cycle.
        set_slot(0, 16'h0000);
        set_slot(1, 16'h2000);
        set_slot(2, 16'h4000);
        set_slot(3, 16'h7FFF);
        req_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("rr_req_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_id",    32'(out_id),    32'(c % 4));
            chk("rr_out_data",  32'(out_data),  32'(rr_exp[c % 4]));
        end

        // Second pass with a negative input on requester 2: symmetry within 1 LSB.
        set_slot(2, 16'hC000);
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("neg_out_id", 32'(out_id), 32'(c));
            if (c == 2) begin
                diff = int'($signed(out_data)) + int'($signed(rr_exp[2]));
                checks++;
                if (diff > 1 || diff < -1) begin
                    errors++;
                    $display("FAIL neg_symmetry: got %0h expected within 1 of -%0h", out_data, rr_exp[2]);
                end
            end else begin
                chk("neg_out_data", 32'(out_data), 32'(rr_exp[c]));
            end
        end

        // Backpressure: result for requester 3 pending, hold out_ready low for 5 cycles.
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_id",    32'(out_id),    32'h3);
            chk("bp_out_data",  32'(out_data),  32'h617B);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("bp_release_id", 32'(out_id), 32'h0);

        // Drop-out: 1 and 2 request, 1 wins, 2 withdraws; grant skips to 3.
        req_valid = 4'b0110;
        #1;
        chk("drop_ready_1", 32'(req_ready), 32'b0010);
        tick();
        chk("drop_id_1",   32'(out_id),   32'h1);
        chk("drop_data_1", 32'(out_data), 32'h1F5A);
        req_valid = 4'b1000;
        #1;
        chk("drop_ready_3", 32'(req_ready), 32'b1000);
        tick();
        chk("drop_id_3", 32'(out_id), 32'h3);
        req_valid = 4'b0000;
        #1;
        chk("drop_idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drop_no_ghost_a", 32'(out_valid), 32'h0);
        chk("drop_hold_id",    32'(out_id),    32'h3);
        tick();
        chk("drop_no_ghost_b", 32'(out_valid), 32'h0);
        req_valid = 4'hF;
        #1;
        chk("drop_ptr_at_3", 32'(req_ready), 32'b0001);
        tick();
        chk("drop_next_id", 32'(out_id), 32'h0);

        // Async reset mid-burst, between clock edges.
        tick();
        chk("arst_pre_valid", 32'(out_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        chk("arst_out_id",    32'(out_id),    32'h0);
        chk("arst_out_data",  32'(out_data),  32'h0);
        tick();
        chk("arst_hold_valid", 32'(out_valid), 32'h0);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_first_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("arst_first_valid", 32'(out_valid), 32'h1);
        chk("arst_first_id",    32'(out_id),    32'h0);

        // Table of single-requester vectors.
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        for (int v = 0; v < 11; v++) begin
            req_data  = '0;
            set_slot(vecs[v].req, vecs[v].x);
            req_valid = NREQ'(1) << vecs[v].req;
            #1;
            chk("vec_req_ready", 32'(req_ready), 32'(NREQ'(1) << vecs[v].req));
            tick();
            chk("vec_out_valid", 32'(out_valid), 32'h1);
            chk("vec_out_id",    32'(out_id),    32'(vecs[v].req));
            chk("vec_out_data",  32'(out_data),  32'(vecs[v].y));
        end
        req_valid = '0;

        // Saturation counter: 10 samples of full scale, 10 of zero, from a fresh reset.
        #3;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        y_full = 16'h617B;
`ifdef TANH_SAT_COUNT_EN
        exp_sat = ($signed(y_full) >= 16'sh7000) ? 10 : 0;
`else
        exp_sat = 0;
`endif
        req_data = '0;
        set_slot(0, 16'h7FFF);
        req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        chk("sat_full_data", 32'(out_data), 32'(y_full));
        set_slot(0, 16'h0000);
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        req_valid = '0;
        tick();
        chk("sat_count", 32'(sat_count), 32'(exp_sat));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
